// File: rtl/mem_access.sv
// mem_access: memory-access stage, IDLE/REQ/WAIT FSM on a valid/ready bus with one outstanding access.
// Latency: non-memory ops 1 cycle; memory ops 1 + req_ready wait + response wait (bounded by TIMEOUT_CYCLES).
// Backpressure: busy holds upstream while an access is in flight; stall freezes the pass-through wb_* bank.
// Option: define MEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of issuing them.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        stall,
  input  logic [63:0] pc,
  input  logic [4:0]  rd,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        load_op,
  input  logic        store_op,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [63:0] req_addr,
  output logic [63:0] req_wdata,
  output logic [7:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [63:0] rsp_data,
  input  logic        rsp_err,
  output logic        busy,
  output logic        wb_en,
  output logic [63:0] wb_pc,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        fault_en,
  output logic [63:0] fault_addr
);

  // The counter only has to reach TIMEOUT_CYCLES-1 before the timeout fires.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [63:0]      pc_q, addr_q;
  logic [4:0]       rd_q;
  logic [1:0]       size_q;
  logic             sext_q, store_q, kill_q;
  logic             mem_op, misalign, start, trap, timeout, ok_done, ok_tmo;
  logic [63:0]      rsp_shift, load_val;
  logic [15:0]      strb_full;

  assign mem_op    = load_op | store_op;
  assign start     = (state == IDLE) & mem_op & ~clear & ~misalign;
  assign trap      = (state == IDLE) & mem_op & ~clear & misalign;
  assign timeout   = (state == WAIT) & ~rsp_valid & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // A clear seen at any point after the handshake (kill_q) or alongside the
  // response consumes the response silently.
  assign ok_done   = (state == WAIT) & rsp_valid & ~kill_q & ~clear;
  assign ok_tmo    = timeout & ~kill_q & ~clear;
  // Byte-enable mask is built 16 bits wide so a doubleword at a nonzero offset truncates cleanly.
  assign strb_full = ((16'd1 << (5'd1 << size)) - 16'd1) << addr[2:0];

`ifdef MEM_MISALIGN_TRAP_EN
  // Natural alignment test for the access size.
  always_comb begin
    misalign = 1'b0;
    case (size)
      2'd1:    misalign = addr[0];
      2'd2:    misalign = |addr[1:0];
      2'd3:    misalign = |addr[2:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and busy; busy rises combinationally in the capture cycle so upstream holds at once.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        busy = start;
        if (start) state_nxt = REQ;
      end
      REQ: begin
        busy = 1'b1;
        if (req_ready)  state_nxt = WAIT;
        else if (clear) state_nxt = IDLE;
      end
      WAIT: begin
        busy = 1'b1;
        if (rsp_valid || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst_n) busy = 1'b0;
  end

  // Bus request fields, loaded at capture and held until the handshake or an abandoning clear.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else if (start) begin
      req_valid <= 1'b1;
      req_we    <= store_op;
      req_addr  <= {addr[63:3], 3'b000};
      req_wdata <= store_op ? (wdata << {addr[2:0], 3'b000}) : '0;
      req_wstrb <= store_op ? strb_full[7:0] : '0;
    end else if (state == REQ && (req_ready || clear)) begin
      req_valid <= 1'b0;
    end
  end

  // Capture of the access context, plus the flag that kills an already-issued access.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q    <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      store_q <= 1'b0;
      kill_q  <= 1'b0;
    end else if (start) begin
      pc_q    <= pc;
      addr_q  <= addr;
      rd_q    <= rd;
      size_q  <= size;
      sext_q  <= sign_ext;
      store_q <= store_op;
      kill_q  <= 1'b0;
    end else if ((state == REQ && req_ready && clear) || (state == WAIT && clear)) begin
      kill_q  <= 1'b1;
    end
  end

  // WAIT cycle counter, restarted on every handshake.
  always_ff @(posedge clk) begin
    if (rst_n)                           wait_cnt <= '0;
    else if (state == REQ && req_ready)  wait_cnt <= '0;
    else if (state == WAIT && !rsp_valid) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Align the response lane to bit 0 and size/extend it.
  always_comb begin
    rsp_shift = rsp_data >> {addr_q[2:0], 3'b000};
    load_val  = rsp_shift;
    case (size_q)
      2'd0:    load_val = {{56{sext_q & rsp_shift[7]}},  rsp_shift[7:0]};
      2'd1:    load_val = {{48{sext_q & rsp_shift[15]}}, rsp_shift[15:0]};
      2'd2:    load_val = {{32{sext_q & rsp_shift[31]}}, rsp_shift[31:0]};
      default: load_val = rsp_shift;
    endcase
  end

  // Writeback and fault outputs. A memory completion always lands (the response
  // cannot be pushed back); otherwise stall holds the wb_* bank.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wb_en      <= 1'b0;
      wb_pc      <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
      fault_en   <= 1'b0;
      fault_addr <= '0;
    end else begin
      fault_en <= 1'b0;
      if (trap) begin
        fault_en   <= 1'b1;
        fault_addr <= addr;
      end
      if (ok_tmo || (ok_done && rsp_err)) begin
        fault_en   <= 1'b1;
        fault_addr <= addr_q;
      end
      if (ok_done && !rsp_err && !store_q && rd_q != 5'd0) begin
        wb_en   <= 1'b1;
        wb_pc   <= pc_q;
        wb_rd   <= rd_q;
        wb_data <= load_val;
      end else if (!stall) begin
        if (state == IDLE && !mem_op && !clear) begin
          wb_en   <= (rd != 5'd0);
          wb_pc   <= pc;
          wb_rd   <= rd;
          wb_data <= addr;
        end else begin
          wb_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed bench for mem_access against a transaction-level model.
// Latency: drives inputs at negedge, samples registered outputs one negedge after the consuming edge.
// Backpressure: exercises req_ready delays, response delays, timeouts, clears and stalls.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n, clear, stall, load_op, store_op, sign_ext;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] pc, addr, wdata, rsp_data;
  logic [4:0]  rd;
  logic [1:0]  size;
  logic        req_valid, req_we, busy, wb_en, fault_en;
  logic [63:0] req_addr, req_wdata, wb_pc, wb_data, fault_addr;
  logic [7:0]  req_wstrb;
  logic [4:0]  wb_rd;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_fault_addr = '0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .stall(stall),
    .pc(pc), .rd(rd), .addr(addr), .wdata(wdata),
    .load_op(load_op), .store_op(store_op), .size(size), .sign_ext(sign_ext),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .wb_en(wb_en), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault_en(fault_en), .fault_addr(fault_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: pick the addressed bytes, keep 2^size of them, extend.
  function automatic logic [63:0] model_load(input logic [63:0] data, input logic [63:0] a,
                                             input logic [1:0] sz, input bit sx);
    int nb;
    logic [63:0] v, mask;
    nb = 1 << sz;
    v  = data >> (8 * a[2:0]);
    if (nb == 8) return v;
    mask = (64'd1 << (8 * nb)) - 64'd1;
    if (sx && v[8*nb-1]) return v | ~mask;
    return v & mask;
  endfunction

  function automatic logic [7:0] model_strb(input logic [63:0] a, input logic [1:0] sz);
    int m;
    m = ((1 << (1 << sz)) - 1) << a[2:0];
    return 8'(m);
  endfunction

  task automatic idle();
    load_op = 1'b0; store_op = 1'b0; clear = 1'b0; stall = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rd = 5'd0;
    pc = rnd64(); addr = rnd64(); wdata = rnd64(); rsp_data = rnd64();
    size = 2'($urandom); sign_ext = 1'($urandom);
  endtask

  // Pipeline noise while busy: must be ignored by the DUT.
  task automatic garbage();
    idle();
    load_op = 1'($urandom); store_op = 1'($urandom); rd = 5'($urandom);
    stall = 1'($urandom);
  endtask

  // cmode: 0 none, 1 clear at capture, 2 clear in REQ, 3 clear in WAIT, 4 clear with response.
  task automatic run_txn(input string nm, input bit st, input logic [1:0] sz, input bit sx,
                         input logic [63:0] a, input logic [63:0] wd, input logic [4:0] r,
                         input int rdly, input int wdly, input bit err,
                         input logic [63:0] rdata, input int cmode);
    logic [63:0] p;
    bit mis, kill, exp_wb, exp_flt;
    p   = rnd64();
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (a % (64'd1 << sz)) != 64'd0;
`endif
    pc = p; rd = r; addr = a; wdata = wd; size = sz; sign_ext = sx;
    load_op = !st; store_op = st; clear = (cmode == 1);
    #1 check({nm, ".busy_cap"}, busy, (cmode == 1 || mis) ? 64'd0 : 64'd1);
    tick();
    if (cmode == 1 || mis) begin
      idle(); #1;
      if (cmode != 1) exp_fault_addr = a;
      check({nm, ".fault_en"}, fault_en, (cmode != 1) ? 64'd1 : 64'd0);
      check({nm, ".fault_addr"}, fault_addr, exp_fault_addr);
      check({nm, ".req_valid"}, req_valid, 0);
      check({nm, ".busy"}, busy, 0);
      check({nm, ".wb_en"}, wb_en, 0);
      tick(); idle(); #1;
      check({nm, ".fault_pulse"}, fault_en, 0);
      check({nm, ".req_valid2"}, req_valid, 0);
      return;
    end
    garbage(); #1;
    for (int k = 0; k <= rdly; k++) begin
      check({nm, ".req_valid"}, req_valid, 1);
      check({nm, ".req_we"}, req_we, st);
      check({nm, ".req_addr"}, req_addr, a & ~64'h7);
      if (st) begin
        check({nm, ".req_wdata"}, req_wdata, wd << (8 * a[2:0]));
        check({nm, ".req_wstrb"}, req_wstrb, model_strb(a, sz));
      end
      check({nm, ".busy_req"}, busy, 1);
      if (cmode == 2) begin
        clear = 1'b1;
        tick(); idle(); #1;
        check({nm, ".clr_req_valid"}, req_valid, 0);
        check({nm, ".clr_busy"}, busy, 0);
        check({nm, ".clr_wb_en"}, wb_en, 0);
        check({nm, ".clr_fault"}, fault_en, 0);
        tick(); idle(); #1;
        check({nm, ".clr_no_req"}, req_valid, 0);
        return;
      end
      if (k == rdly) req_ready = 1'b1;
      tick(); garbage(); #1;
    end
    check({nm, ".req_done"}, req_valid, 0);
    check({nm, ".busy_wait"}, busy, 1);
    kill = (cmode == 3) || (cmode == 4 && wdly < TO);
    if (wdly >= TO) begin
      for (int i = 0; i < TO; i++) begin
        clear = (cmode == 3 && i == 0);
        #1 check({nm, ".tmo_busy"}, busy, 1);
        check({nm, ".tmo_early"}, fault_en, 0);
        tick(); garbage();
      end
      idle(); #1;
      exp_flt = (cmode != 3);
      if (exp_flt) exp_fault_addr = a;
      check({nm, ".tmo_fault"}, fault_en, exp_flt);
      check({nm, ".tmo_addr"}, fault_addr, exp_fault_addr);
      check({nm, ".tmo_busy_end"}, busy, 0);
      check({nm, ".tmo_wb_en"}, wb_en, 0);
      rsp_valid = 1'b1; rsp_err = 1'($urandom);
      tick(); idle(); #1;
      check({nm, ".stray_wb_en"}, wb_en, 0);
      check({nm, ".stray_fault"}, fault_en, 0);
      check({nm, ".stray_busy"}, busy, 0);
    end else begin
      for (int i = 0; i < wdly; i++) begin
        clear = (cmode == 3 && i == 0);
        #1 check({nm, ".wait_busy"}, busy, 1);
        tick(); garbage();
      end
      clear = (cmode == 4) || (cmode == 3 && wdly == 0);
      rsp_valid = 1'b1; rsp_err = err; rsp_data = rdata;
      #1 check({nm, ".busy_rsp"}, busy, 1);
      tick(); idle(); #1;
      exp_wb  = !kill && !err && !st && (r != 5'd0);
      exp_flt = !kill && err;
      if (exp_flt) exp_fault_addr = a;
      check({nm, ".wb_en"}, wb_en, exp_wb);
      if (exp_wb) begin
        check({nm, ".wb_data"}, wb_data, model_load(rdata, a, sz, sx));
        check({nm, ".wb_pc"}, wb_pc, p);
        check({nm, ".wb_rd"}, wb_rd, r);
      end
      check({nm, ".fault_en"}, fault_en, exp_flt);
      check({nm, ".fault_addr"}, fault_addr, exp_fault_addr);
      check({nm, ".busy_done"}, busy, 0);
      tick(); idle(); #1;
      check({nm, ".wb_pulse"}, wb_en, 0);
      check({nm, ".fault_pulse"}, fault_en, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        m_en;
    logic [63:0] m_pc, m_data;
    logic [4:0]  m_rd;
    int          cm, wd;

    // Reset with live inputs: everything must read zero.
    rst_n = 1'b1;
    idle();
    load_op = 1'b1; rd = 5'd3;
    tick(); tick(); #1;
    check("rst.req_valid", req_valid, 0);
    check("rst.req_we", req_we, 0);
    check("rst.req_addr", req_addr, 0);
    check("rst.req_wdata", req_wdata, 0);
    check("rst.req_wstrb", req_wstrb, 0);
    check("rst.busy", busy, 0);
    check("rst.wb_en", wb_en, 0);
    check("rst.wb_pc", wb_pc, 0);
    check("rst.wb_rd", wb_rd, 0);
    check("rst.wb_data", wb_data, 0);
    check("rst.fault_en", fault_en, 0);
    check("rst.fault_addr", fault_addr, 0);

    // Pass-through of non-memory ops with random stall/clear.
    rst_n = 1'b0;
    m_en = 1'b0; m_pc = '0; m_rd = '0; m_data = '0;
    for (int i = 0; i < 40; i++) begin
      idle();
      rd    = 5'($urandom_range(3) == 0 ? 0 : $urandom);
      stall = ($urandom_range(3) == 0);
      clear = ($urandom_range(5) == 0);
      #1 check("pt.busy", busy, 0);
      if (!stall) begin
        if (clear) m_en = 1'b0;
        else begin
          m_en = (rd != 5'd0); m_pc = pc; m_rd = rd; m_data = addr;
        end
      end
      tick();
      check("pt.wb_en", wb_en, m_en);
      check("pt.wb_pc", wb_pc, m_pc);
      check("pt.wb_rd", wb_rd, m_rd);
      check("pt.wb_data", wb_data, m_data);
      check("pt.fault_en", fault_en, 0);
      check("pt.req_valid", req_valid, 0);
    end
    idle(); #1;

    // Directed scenarios.
    run_txn("ld_b_sext", 0, 2'd0, 1, 64'h1003, 64'h0, 5'd5, 0, 1, 0, 64'h0000_0000_8000_0000, 0);
    run_txn("st_h", 1, 2'd1, 0, 64'h2006, 64'hBEEF, 5'd7, 3, 1, 0, rnd64(), 0);
    run_txn("ld_w_err", 0, 2'd2, 0, 64'h4008, 64'h0, 5'd9, 0, 2, 1, rnd64(), 0);
    run_txn("timeout", 0, 2'd3, 0, 64'h5000, 64'h0, 5'd3, 1, TO, 0, 64'h0, 0);
    run_txn("clr_wait", 0, 2'd3, 1, 64'h6010, 64'h0, 5'd4, 0, 2, 0, rnd64(), 3);
    run_txn("clr_idle", 0, 2'd2, 0, 64'h6100, 64'h0, 5'd4, 0, 1, 0, rnd64(), 1);
    run_txn("clr_req", 1, 2'd3, 0, 64'h6200, rnd64(), 5'd4, 2, 1, 0, rnd64(), 2);
    run_txn("clr_rsp", 0, 2'd0, 1, 64'h6301, 64'h0, 5'd8, 1, 1, 0, rnd64(), 4);
    run_txn("clr_tmo", 0, 2'd1, 0, 64'h6402, 64'h0, 5'd8, 0, TO, 0, 64'h0, 3);
    run_txn("ld_rd0", 0, 2'd3, 0, 64'h6500, 64'h0, 5'd0, 0, 0, 0, rnd64(), 0);
    run_txn("rsp_at_limit", 0, 2'd2, 1, 64'h6604, 64'h0, 5'd11, 0, TO - 1, 0, rnd64(), 0);
    run_txn("ld_d_off", 0, 2'd3, 0, 64'h3004, 64'h0, 5'd12, 0, 1, 0, rnd64(), 0);
    run_txn("st_d_off", 1, 2'd3, 0, 64'h3005, rnd64(), 5'd12, 1, 0, 0, rnd64(), 0);

    // Reset in WAIT abandons the access; the late response is ignored.
    idle();
    rd = 5'd6; addr = 64'h7000; size = 2'd3; load_op = 1'b1;
    tick(); garbage(); req_ready = 1'b1;
    tick(); garbage(); #1;
    check("rst_mid.busy_wait", busy, 1);
    rst_n = 1'b1;
    tick(); rst_n = 1'b0; idle(); #1;
    exp_fault_addr = '0;
    check("rst_mid.busy", busy, 0);
    check("rst_mid.req_valid", req_valid, 0);
    check("rst_mid.wb_data", wb_data, 0);
    check("rst_mid.fault_addr", fault_addr, 0);
    rsp_valid = 1'b1; rsp_data = rnd64();
    #1 check("rst_mid.busy_rsp", busy, 0);
    tick(); idle(); #1;
    check("rst_mid.wb_en", wb_en, 0);
    check("rst_mid.fault_en", fault_en, 0);
    check("rst_mid.req_valid2", req_valid, 0);

    // Random transactions.
    for (int i = 0; i < 80; i++) begin
      cm = $urandom_range(9);
      cm = (cm <= 5) ? 0 : cm - 5;
      wd = ($urandom_range(4) == 0) ? TO : int'($urandom_range(TO - 1));
      run_txn("rnd", 1'($urandom), 2'($urandom), 1'($urandom), rnd64(), rnd64(),
              5'($urandom), int'($urandom_range(3)), wd, ($urandom_range(5) == 0),
              rnd64(), cm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
